// File: rtl/floating_add_cmp_conv_pkg.sv
// Shared encodings and IEEE-754 single-precision field constants for the
// add/sub, compare and int-to-float unit.
package floating_add_cmp_conv_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_I2F = 2'b10,
    OP_CMP = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_GT = 2'b01,
    CMP_UN = 2'b10,
    CMP_LT = 2'b11
  } cmp_e;

endpackage

// File: rtl/fp_lzc.sv
// 32-bit leading-zero counter; an all-zero input reports 32.
module fp_lzc (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  // Scanning upward lets the highest set bit overwrite earlier hits.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/floating_add_cmp_conv.sv
// Single-cycle IEEE-754 single add/sub, compare and int32-to-float unit with
// one output register stage; subnormals are treated as signed zero.
module floating_add_cmp_conv
  import floating_add_cmp_conv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic [1:0]  cmp,
  output logic        valid,
  output logic [31:0] debug
);

  localparam int WORD_W   = SIGN_W + EXP_W + FRAC_W;
  localparam int SIGN_BIT = WORD_W - 1;

  op_e op_sel;
  assign op_sel = op_e'(op);

  logic              sign_a, sign_b;
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [WORD_W-2:0] mag_a, mag_b;
  logic [23:0]       man_a, man_b;

  assign sign_a = a[SIGN_BIT];
  assign sign_b = b[SIGN_BIT] ^ (op_sel == OP_SUB);
  assign exp_a  = a[SIGN_BIT-1:FRAC_W];
  assign exp_b  = b[SIGN_BIT-1:FRAC_W];
  assign frac_a = a[FRAC_W-1:0];
  assign frac_b = b[FRAC_W-1:0];
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (exp_a == EXP_MAX) && (frac_a == '0);
  assign inf_b  = (exp_b == EXP_MAX) && (frac_b == '0);
  assign nan_a  = (exp_a == EXP_MAX) && (frac_a != '0);
  assign nan_b  = (exp_b == EXP_MAX) && (frac_b != '0);
  assign mag_a  = zero_a ? '0 : a[SIGN_BIT-1:0];
  assign mag_b  = zero_b ? '0 : b[SIGN_BIT-1:0];
  assign man_a  = zero_a ? 24'd0 : {1'b1, frac_a};
  assign man_b  = zero_b ? 24'd0 : {1'b1, frac_b};

  logic             a_big, sign_big, eff_sub;
  logic [EXP_W-1:0] exp_big, exp_small, align_diff;
  logic [4:0]       align_amt;
  logic [23:0]      man_big, man_small;
  logic [49:0]      small_wide;
  logic [26:0]      big_ext, small_ext;
  logic [27:0]      sum;

  assign a_big     = (mag_a >= mag_b);
  assign sign_big  = a_big ? sign_a : sign_b;
  assign eff_sub   = sign_a ^ sign_b;
  assign exp_big   = a_big ? exp_a : exp_b;
  assign exp_small = a_big ? exp_b : exp_a;
  assign man_big   = a_big ? man_a : man_b;
  assign man_small = a_big ? man_b : man_a;

  // Any shift of 27 or more leaves only sticky, so 31 is a safe cap.
  assign align_diff = exp_big - exp_small;
  assign align_amt  = (align_diff > 8'd31) ? 5'd31 : align_diff[4:0];
  assign small_wide = {man_small, 26'd0} >> align_amt;
  assign small_ext  = {small_wide[49:24], |small_wide[23:0]};
  assign big_ext    = {man_big, 3'b000};
  assign sum = eff_sub ? ({1'b0, big_ext} - {1'b0, small_ext})
                       : ({1'b0, big_ext} + {1'b0, small_ext});

  logic [31:0] int_mag, lzc_in, norm;
  logic [5:0]  lz;

  assign int_mag = a[31] ? (~a + 32'd1) : a;
  assign lzc_in  = (op_sel == OP_I2F) ? int_mag : {sum, 4'd0};

  fp_lzc u_lzc (
    .value (lzc_in),
    .count (lz)
  );

  // Both paths normalise into the same frame: 24-bit mantissa, guard, sticky.
  logic [23:0]        mant;
  logic               guard, sticky, round_up;
  logic [24:0]        mant_rnd;
  logic [FRAC_W-1:0]  frac_rnd;
  logic signed [9:0]  exp_pre, exp_fin;

  assign norm     = lzc_in << lz;
  assign mant     = norm[31:8];
  assign guard    = norm[7];
  assign sticky   = |norm[6:0];
  assign round_up = guard & (sticky | mant[0]);
  assign mant_rnd = {1'b0, mant} + {24'd0, round_up};
  assign frac_rnd = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
  assign exp_pre  = (op_sel == OP_I2F) ? (10'(BIAS + 31) - {4'd0, lz})
                                       : ({2'd0, exp_big} + 10'd1 - {4'd0, lz});
  assign exp_fin  = exp_pre + {9'd0, mant_rnd[24]};

  logic [31:0] add_res, i2f_res;
  cmp_e        cmp_code;
  logic        key_sign_a, key_sign_b;

  always_comb begin
    add_res = {sign_big, exp_fin[7:0], frac_rnd};
    if (nan_a || nan_b)          add_res = QNAN;
    else if (inf_a && inf_b)     add_res = (sign_a != sign_b) ? QNAN : {sign_a, EXP_MAX, {FRAC_W{1'b0}}};
    else if (inf_a)              add_res = {sign_a, EXP_MAX, {FRAC_W{1'b0}}};
    else if (inf_b)              add_res = {sign_b, EXP_MAX, {FRAC_W{1'b0}}};
    else if (zero_a && zero_b)   add_res = {sign_a & sign_b, 31'd0};
    else if (sum == 28'd0)       add_res = 32'd0;
    else if (exp_fin >= 10'sd255) add_res = {sign_big, EXP_MAX, {FRAC_W{1'b0}}};
    else if (exp_fin <= 10'sd0)  add_res = {sign_big, 31'd0};
  end

  assign i2f_res = (a == 32'd0) ? 32'd0 : {a[31], exp_fin[7:0], frac_rnd};

  assign key_sign_a = sign_a & ~zero_a;
  assign key_sign_b = sign_b & ~zero_b;

  // Signed zero collapses to positive so +0 and -0 compare equal.
  always_comb begin
    cmp_code = CMP_EQ;
    if (nan_a || nan_b)                  cmp_code = CMP_UN;
    else if (key_sign_a != key_sign_b)   cmp_code = key_sign_a ? CMP_LT : CMP_GT;
    else if (mag_a == mag_b)             cmp_code = CMP_EQ;
    else if ((mag_a > mag_b) ^ key_sign_a) cmp_code = CMP_GT;
    else                                 cmp_code = CMP_LT;
  end

  logic [31:0] next_result;
  logic [1:0]  next_cmp;
  logic [7:0]  align_dbg, norm_dbg;

  always_comb begin
    next_result = 32'd0;
    next_cmp    = CMP_EQ;
    align_dbg   = 8'd0;
    norm_dbg    = {2'd0, lz};
    case (op_sel)
      OP_ADD, OP_SUB: begin
        next_result = add_res;
        align_dbg   = align_diff;
      end
      OP_I2F: next_result = i2f_res;
      OP_CMP: begin
        next_cmp = cmp_code;
        norm_dbg = 8'd0;
      end
      default: next_result = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid  <= 1'b0;
      result <= 32'd0;
      cmp    <= 2'd0;
      debug  <= 32'd0;
    end else begin
      valid <= en;
      if (en) begin
        result <= next_result;
        cmp    <= next_cmp;
        debug  <= {14'd0, op, norm_dbg, align_dbg};
      end
    end
  end

endmodule

// File: tb/tb_floating_add_cmp_conv.sv
// Scoreboard bench: a wide-integer exact-arithmetic model predicts each
// response at issue time; a negedge monitor pops and compares.
module tb_floating_add_cmp_conv;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk;
  logic        reset;
  logic        en;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [31:0] result;
  logic [1:0]  cmp;
  logic        valid;
  logic [31:0] debug;

  floating_add_cmp_conv dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .cmp    (cmp),
    .valid  (valid),
    .debug  (debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] result;
    logic [1:0]  cmp;
    bit          chk_align;
    logic [7:0]  align;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int fails = 0;
  logic [31:0] hold_result = 32'd0;
  logic [1:0]  hold_cmp = 2'd0;
  bit reset_at_edge = 1'b1;
  bit seen_edge = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic bit is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic bit is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  function automatic bit is_normal(input logic [31:0] x);
    return (x[30:23] != 8'h00) && (x[30:23] != 8'hFF);
  endfunction

  // Rounds the exact magnitude mag * 2^(bit position) to 24 bits, nearest-even;
  // base is the biased exponent a leading one at bit 0 would carry.
  function automatic logic [31:0] round_pack(input bit s, input logic [299:0] mag, input int base);
    int p;
    int sh;
    int e;
    logic [299:0] q, rem, half;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((300'd1 << sh) - 300'd1);
      half = 300'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 300'd1;
      if (q[24]) begin
        q = q >> 1;
        p = p + 1;
      end
    end else begin
      q = mag << (23 - p);
    end
    e = base + p;
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic [299:0] mx, my, s;
    int ex, ey, emin;
    bit sg;
    if (is_nan(x) || is_nan(y)) return QNAN;
    if (is_inf(x) && is_inf(y)) return (x[31] != y[31]) ? QNAN : x;
    if (is_inf(x)) return x;
    if (is_inf(y)) return y;
    if (is_zero(x) && is_zero(y)) return {x[31] & y[31], 31'd0};
    if (is_zero(x)) return y;
    if (is_zero(y)) return x;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    emin = (ex < ey) ? ex : ey;
    mx = 300'({1'b1, x[22:0]}) << (ex - emin);
    my = 300'({1'b1, y[22:0]}) << (ey - emin);
    if (x[31] == y[31]) begin
      s = mx + my;
      sg = x[31];
    end else if (mx >= my) begin
      s = mx - my;
      sg = x[31];
    end else begin
      s = my - mx;
      sg = y[31];
    end
    if (s == 300'd0) return 32'd0;
    return round_pack(sg, s, emin - 23);
  endfunction

  function automatic logic [31:0] ref_i2f(input logic [31:0] x);
    logic [31:0] m;
    if (x == 32'd0) return 32'd0;
    m = x[31] ? (~x + 32'd1) : x;
    return round_pack(x[31], 300'(m), 127);
  endfunction

  function automatic longint order_key(input logic [31:0] x);
    longint m;
    if (is_zero(x)) return 0;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [1:0] ref_cmp(input logic [31:0] x, input logic [31:0] y);
    longint kx, ky;
    if (is_nan(x) || is_nan(y)) return 2'b10;
    kx = order_key(x);
    ky = order_key(y);
    if (kx == ky) return 2'b00;
    return (kx > ky) ? 2'b01 : 2'b11;
  endfunction

  function automatic logic [31:0] rand_fp(input logic [7:0] near);
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom;
    case ($urandom_range(0, 15))
      0: return {r[31], 31'd0};
      1: return {r[31], 8'd0, r[22:0] | 23'd1};
      2: return {r[31], 8'hFF, 23'd0};
      3: return {r[31], 8'hFF, r[22:0] | 23'd1};
      4: e = 8'($urandom_range(252, 254));
      5: e = 8'($urandom_range(1, 3));
      6, 7, 8, 9: e = (near == 8'd0 || near == 8'hFF) ? 8'd127 : near;
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {r[31], e, r[22:0]};
  endfunction

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    en = 1'b1;
    op = o;
    a  = x;
    b  = y;
    e.op = o;
    e.result = 32'd0;
    e.cmp = 2'd0;
    e.chk_align = 1'b0;
    e.align = 8'd0;
    case (o)
      2'b00: e.result = ref_add(x, y);
      2'b01: e.result = ref_add(x, y ^ 32'h8000_0000);
      2'b10: e.result = ref_i2f(x);
      default: e.cmp = ref_cmp(x, y);
    endcase
    if (o[1] == 1'b0 && is_normal(x) && is_normal(y)) begin
      e.chk_align = 1'b1;
      e.align = (x[30:23] > y[30:23]) ? (x[30:23] - y[30:23]) : (y[30:23] - x[30:23]);
    end
    if (reset) sb_q.push_back(e);
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  always @(posedge clk) begin
    reset_at_edge = reset;
    seen_edge = 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (seen_edge) begin
      if (!reset_at_edge) begin
        checkOutput("reset valid", {31'd0, valid}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset cmp", {30'd0, cmp}, 32'd0);
        checkOutput("reset debug", debug, 32'd0);
        hold_result = 32'd0;
        hold_cmp = 2'd0;
      end else if (valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("spurious valid", {31'd0, valid}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("result", result, e.result);
          checkOutput("cmp", {30'd0, cmp}, {30'd0, e.cmp});
          checkOutput("debug op field", {16'd0, debug[31:16]}, {30'd0, e.op});
          if (e.chk_align) checkOutput("debug align", {24'd0, debug[7:0]}, {24'd0, e.align});
          hold_result = e.result;
          hold_cmp = e.cmp;
        end
      end else begin
        checkOutput("hold result", result, hold_result);
        checkOutput("hold cmp", {30'd0, cmp}, {30'd0, hold_cmp});
      end
    end
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] x, y;
    reset = 1'b0;
    en = 1'b0;
    op = 2'b00;
    a = 32'd0;
    b = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    applyStimulus(2'b00, 32'h3F80_0000, 32'h4000_0000);
    @(posedge clk); #1;
    applyStimulus(2'b01, 32'h3F80_0000, 32'h3F80_0000);
    applyStimulus(2'b00, 32'h7F80_0000, 32'hFF80_0000);
    applyStimulus(2'b10, 32'hFFFF_FFFF, 32'd0);
    applyStimulus(2'b10, 32'd16777217, 32'd0);
    applyStimulus(2'b10, 32'h8000_0000, 32'd0);
    applyStimulus(2'b10, 32'd0, 32'd0);
    applyStimulus(2'b11, 32'h3F80_0000, 32'h4000_0000);
    applyStimulus(2'b11, 32'h4000_0000, 32'h3F80_0000);
    applyStimulus(2'b11, 32'h8000_0000, 32'h0000_0000);
    applyStimulus(2'b11, 32'h7FC0_0000, 32'h3F80_0000);
    applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000);
    applyStimulus(2'b00, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
    applyStimulus(2'b01, 32'h0180_0001, 32'h0180_0000);
    applyStimulus(2'b00, 32'hFF80_0000, 32'h4120_0000);
    applyStimulus(2'b00, 32'h4B80_0000, 32'h3F80_0000);
    @(posedge clk); #1;

    applyStimulus(2'b00, 32'h4040_0000, 32'h3F00_0000);
    applyStimulus(2'b10, 32'd1000, 32'd0);
    applyStimulus(2'b11, 32'hC000_0000, 32'hBF80_0000);
    applyStimulus(2'b01, 32'h3F80_0000, 32'h4080_0000);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      o = 2'($urandom_range(0, 3));
      x = rand_fp(8'd127);
      y = rand_fp(x[30:23]);
      if (o == 2'b10) begin
        case ($urandom_range(0, 2))
          0: x = 32'($urandom_range(0, 2000)) - 32'd1000;
          1: x = $urandom >> $urandom_range(0, 8);
          default: x = $urandom;
        endcase
      end
      if (o == 2'b11 && $urandom_range(0, 4) == 0) y = ($urandom_range(0, 1) == 0) ? x : (x ^ 32'h8000_0000);
      applyStimulus(o, x, y);
    end

    applyStimulus(2'b00, 32'h3F80_0000, 32'h4000_0000);
    reset = 1'b0;
    applyStimulus(2'b00, 32'h4000_0000, 32'h4000_0000);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/floating_add_cmp_conv.md
FLOATING_ADD_CMP_CONV -- requirements
Module: floating_add_cmp_conv

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset sampled on clk rising edge.
REQ-003 SHALL have port en, input, 1, start pulse: operands and op sampled on any edge with en=1.
REQ-004 SHALL have port op, input, 2, operation: 00 add, 01 sub (a-b), 10 signed int32 to float, 11 compare.
REQ-005 SHALL have port a, input, 32, operand A: IEEE-754 single, or two's-complement int for op=10.
REQ-006 SHALL have port b, input, 32, operand B: IEEE-754 single; ignored for op=10.
REQ-007 SHALL have port result, output, 32, IEEE-754 single result for op 00/01/10; 0 for op=11.
REQ-008 SHALL have port cmp, output, 2, compare code for op=11; 00 for other ops.
REQ-009 SHALL have port valid, output, 1, high exactly one cycle after each en=1 cycle.
REQ-010 SHALL have port debug, output, 32: [7:0] alignment shift, [15:8] normalization shift, [17:16] op, [31:18] zero.

Function
REQ-011 SHALL be fully pipelined, latency 1: result/cmp/debug registered on edge after en sample; throughput one op per cycle.
REQ-012 SHALL hold result, cmp and debug unchanged while en=0; valid=0 in those cycles.
REQ-013 Add/sub SHALL align smaller exponent with guard/round/sticky, add magnitudes, normalize, round to nearest-even.
REQ-014 Sub SHALL be add with sign of b inverted.
REQ-015 Exact-zero sum SHALL be +0, except (-0)+(-0) = -0.
REQ-016 Subnormal inputs SHALL be treated as signed zero; subnormal results SHALL flush to signed zero.
REQ-017 Exponent overflow after rounding SHALL give signed infinity (0x7F800000/0xFF800000).
REQ-018 Any NaN input, or inf-inf of opposite effective sign, SHALL give canonical qNaN 0x7FC00000.
REQ-019 Inf plus finite SHALL return that infinity.
REQ-020 Int-to-float SHALL convert signed 32-bit a, round to nearest-even; 0 -> 0x00000000; -2^31 -> 0xCF000000.
REQ-021 Compare SHALL produce cmp: 00 a==b, 01 a>b, 11 a<b, 10 unordered (either operand NaN).
REQ-022 Compare SHALL treat +0 and -0 as equal and subnormals as zero.
REQ-023 Compare SHALL order by sign, then exponent, then mantissa, with magnitude order reversed for negatives.

Reset
REQ-024 While reset=0 at a rising edge, result, cmp, debug SHALL clear to 0 and valid to 0, regardless of en.
REQ-025 An en sampled in a reset cycle SHALL be discarded; no valid pulse SHALL follow.
REQ-026 First operation SHALL be accepted on first edge with reset=1 and en=1.

Structure
REQ-027 Shared package SHALL hold op encodings, cmp encodings, QNAN constant 0x7FC00000, field widths (sign 1, exp 8, frac 23), bias 127.
REQ-028 SHALL instantiate one sub-module, fp_lzc: 32-bit leading-zero counter for normalization in add/sub and int-to-float.
REQ-029 Remaining datapath SHALL be combinational ahead of a single output register stage.

Verification
REQ-030 en, op=00, a=0x3F800000, b=0x40000000 -> next cycle valid=1, result=0x40400000.
REQ-031 op=01, a=b=0x3F800000 -> result 0x00000000; op=00, a=0x7F800000, b=0xFF800000 -> 0x7FC00000.
REQ-032 op=10: a=0xFFFFFFFF -> 0xBF800000; a=16777217 -> 0x4B800000 (tie to even); a=0x80000000 -> 0xCF000000.
REQ-033 op=11: (0x3F800000, 0x40000000) -> cmp 11; swapped -> 01; (0x80000000, 0x00000000) -> 00; a=0x7FC00000 -> 10.
REQ-034 en high 4 consecutive cycles with mixed ops -> 4 consecutive valid pulses, results in order.
REQ-035 Assert reset=0 in the cycle after en -> valid stays 0, all outputs 0 the next cycle.
